// File: rtl/adder_pkg.sv
// Shared configuration for the pipelined carry-select adder family:
// default geometry, stage-count helper and operation encoding.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of pipeline stages, one per segment.
  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  // Geometry is legal only when the width splits into whole segments.
  function automatic bit seg_ok(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: both candidate sums are formed up front and the
// incoming carry only drives the final select.
module csel_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic [SEG-1:0] sum,
  output logic           carry_out,
  output logic           carry_into_msb
);

  localparam int unsigned SW = SEG + 1;

  logic [SEG:0] s0;
  logic [SEG:0] s1;

  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + SW'(1);

  assign {carry_out, sum} = carry_in ? s1 : s0;

  // Carry entering the top bit recovered from the top-bit sum relation.
  assign carry_into_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor: one segment of the carry chain
// resolves per stage, with valid/ready flow control over the whole pipe.
module pipe_csel_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG);

  if (!seg_ok(WIDTH, SEG)) begin : g_cfg_err
    $error("pipe_csel_adder: WIDTH must be a positive multiple of SEG");
  end

  logic             en;
  logic             c_eff;
  logic [WIDTH-1:0] b_eff;

  logic [NSEG-1:0]  v_q, v_d;
  logic [NSEG-1:0]  c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];

  logic [SEG-1:0]   seg_a [NSEG];
  logic [SEG-1:0]   seg_b [NSEG];
  logic [SEG-1:0]   seg_s [NSEG];
  logic [NSEG-1:0]  seg_ci;
  logic [NSEG-1:0]  seg_co;
  logic             seg_cm [NSEG];

  // The whole pipe advances together whenever the output slot can drain.
  assign en       = !v_q[NSEG-1] || out_ready;
  assign in_ready = en;

  assign b_eff = (sub == OP_SUB) ? ~inb : inb;
  assign c_eff = (sub == OP_SUB) ? 1'b1 : cin;

  // Stage k adds segment k of operands carried down by the skew registers.
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    if (k == 0) begin : g_head
      assign seg_a[k]  = ina[SEG-1:0];
      assign seg_b[k]  = b_eff[SEG-1:0];
      assign seg_ci[k] = c_eff;
    end else begin : g_body
      assign seg_a[k]  = a_q[k-1][k*SEG +: SEG];
      assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
      assign seg_ci[k] = c_q[k-1];
    end

    csel_segment #(
      .SEG (SEG)
    ) u_seg (
      .a              (seg_a[k]),
      .b              (seg_b[k]),
      .carry_in       (seg_ci[k]),
      .sum            (seg_s[k]),
      .carry_out      (seg_co[k]),
      .carry_into_msb (seg_cm[k])
    );
  end

  // Next-state: shift every slot one stage and merge the newly resolved segment.
  always_comb begin
    v_d   = v_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    if (en) begin
      v_d[0] = in_valid;
      a_d[0] = ina;
      b_d[0] = b_eff;
      s_d[0] = WIDTH'(seg_s[0]);
      for (int k = 1; k < int'(NSEG); k++) begin
        v_d[k]                = v_q[k-1];
        a_d[k]                = a_q[k-1];
        b_d[k]                = b_q[k-1];
        s_d[k]                = s_q[k-1];
        s_d[k][k*SEG +: SEG]  = seg_s[k];
      end
      c_d   = seg_co;
      ovf_d = seg_co[NSEG-1] ^ seg_cm[NSEG-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NSEG); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Directed and randomised checks of pipe_csel_adder at 32/8 plus narrower
// and wider geometries against an independent add/subtract model.
`timescale 1ns/1ps
module tb_pipe_csel_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] ina, inb;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf;

  logic        v_s, cin_s, sub_s;
  logic [63:0] a_s, b_s;
  logic        r16, ir16, ov16, co16, of16;
  logic [15:0] s16;
  logic        r8, ir8, ov8, co8, of8;
  logic [7:0]  s8;
  logic        r64, ir64, ov64, co64, of64;
  logic [63:0] s64;

  int checks;
  int passed;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        of;
  } vec_t;

  vec_t tv [11];

  pipe_csel_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_csel_adder #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_s), .in_ready(ir16),
    .ina(a_s[15:0]), .inb(b_s[15:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov16),
    .out_ready(r16), .sum(s16), .cout(co16), .ovf(of16)
  );

  pipe_csel_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_s), .in_ready(ir8),
    .ina(a_s[7:0]), .inb(b_s[7:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov8),
    .out_ready(r8), .sum(s8), .cout(co8), .ovf(of8)
  );

  pipe_csel_adder #(.WIDTH(64), .SEG(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_s), .in_ready(ir64),
    .ina(a_s), .inb(b_s), .cin(cin_s), .sub(sub_s), .out_valid(ov64),
    .out_ready(r64), .sum(s64), .cout(co64), .ovf(of64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {cout, ovf, sum} for a w-bit A+B+cin or A-B.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, am, bb, s;
    logic [64:0] full;
    logic        c, co, of;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bb   = (sb ? ~b : b) & mask;
    c    = sb ? 1'b1 : ci;
    full = {1'b0, am} + {1'b0, bb} + 65'(c);
    s    = full[63:0] & mask;
    co   = full[w];
    of   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {co, of, s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; ina = 32'hDEAD_BEEF; inb = 32'h0000_1234;
    cin = 1'b1; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (sum !== 32'h0) $display("FAIL reset_sum: got %h want 00000000", sum); else passed++;
    checks++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_idle_%0d: out_valid got %b want 0", i, out_valid);
      else passed++;
    end
  endtask

  task automatic test_directed();
    int lat;
    tv[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tv[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tv[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[4]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[6]  = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
    tv[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tv[8]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    tv[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tv[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ina = tv[i].a; inb = tv[i].b; cin = tv[i].ci; sub = tv[i].sb;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); else passed++;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++; if (lat != 4) $display("FAIL dir%0d_latency: got %0d want 4", i, lat); else passed++;
      checks++; if (sum !== tv[i].s) $display("FAIL dir%0d_sum: got %h want %h", i, sum, tv[i].s); else passed++;
      checks++; if (cout !== tv[i].co) $display("FAIL dir%0d_cout: got %b want %b", i, cout, tv[i].co); else passed++;
      checks++; if (ovf !== tv[i].of) $display("FAIL dir%0d_ovf: got %b want %b", i, ovf, tv[i].of); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [65:0] q [$];
    logic [65:0] exp, got;
    logic [31:0] held;
    logic [31:0] na, nb;
    logic        nc, ns, exp_rdy;
    int sent, rcvd;
    sent = 0; rcvd = 0; held = '0;
    na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
    for (int idx = 0; idx < 60 && rcvd < 10; idx++) begin
      @(negedge clk);
      in_valid = (sent < 10); ina = na; inb = nb; cin = nc; sub = ns;
      out_ready = !(idx >= 6 && idx <= 9);
      exp_rdy = out_ready;
      #1;
      checks++;
      if (in_ready !== exp_rdy) $display("FAIL bp_in_ready_c%0d: got %b want %b", idx, in_ready, exp_rdy);
      else passed++;
      if (idx == 6) held = sum;
      if (idx >= 7 && idx <= 9) begin
        checks++;
        if ({out_valid, sum} !== {1'b1, held}) $display("FAIL bp_hold_c%0d: got %b/%h want 1/%h", idx, out_valid, sum, held);
        else passed++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(32, {32'd0, na}, {32'd0, nb}, nc, ns));
        sent++;
        na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_ready) begin
        got = {cout, ovf, 32'd0, sum};
        exp = (q.size() > 0) ? q.pop_front() : '1;
        checks++;
        if (got !== exp) $display("FAIL bp_result_%0d: got %h want %h", rcvd, got, exp);
        else passed++;
        rcvd++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcvd != 10) $display("FAIL bp_count: got %0d want 10", rcvd); else passed++;
    checks++; if (q.size() != 0) $display("FAIL bp_leftover: got %0d want 0", q.size()); else passed++;
  endtask

  task automatic test_reset_midflight();
    int lat, spur;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ina = 32'(i + 1); inb = 32'h10; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_flush: got %b want 0", out_valid); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spur++;
    end
    checks++; if (spur != 0) $display("FAIL mid_spurious: got %0d want 0", spur); else passed++;
    in_valid = 1'b1; ina = 32'h0000_FFFF; inb = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 4) $display("FAIL mid_latency: got %0d want 4", lat); else passed++;
    checks++;
    if ({cout, ovf, sum} !== {1'b0, 1'b0, 32'h0001_0000})
      $display("FAIL mid_result: got %b%b/%h want 00/00010000", cout, ovf, sum);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [65:0] q16 [$];
    logic [65:0] q8 [$];
    logic [65:0] q64 [$];
    logic [65:0] exp, got;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      v_s   = (cyc < 2960) && ($urandom_range(0, 3) != 0);
      a_s   = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
      b_s   = ($urandom_range(0, 7) == 0) ? 64'd1 : {$urandom, $urandom};
      cin_s = 1'($urandom_range(0, 1));
      sub_s = 1'($urandom_range(0, 1));
      r16   = (cyc >= 2960) || ($urandom_range(0, 3) != 0);
      r8    = (cyc >= 2960) || ($urandom_range(0, 3) != 0);
      r64   = (cyc >= 2960) || ($urandom_range(0, 3) != 0);
      #1;
      if (v_s && ir16) q16.push_back(model(16, a_s, b_s, cin_s, sub_s));
      if (v_s && ir8)  q8.push_back(model(8, a_s, b_s, cin_s, sub_s));
      if (v_s && ir64) q64.push_back(model(64, a_s, b_s, cin_s, sub_s));
      if (ov16 && r16) begin
        got = {co16, of16, 48'd0, s16};
        exp = (q16.size() > 0) ? q16.pop_front() : '1;
        checks++; if (got !== exp) $display("FAIL sweep16_c%0d: got %h want %h", cyc, got, exp); else passed++;
      end
      if (ov8 && r8) begin
        got = {co8, of8, 56'd0, s8};
        exp = (q8.size() > 0) ? q8.pop_front() : '1;
        checks++; if (got !== exp) $display("FAIL sweep8_c%0d: got %h want %h", cyc, got, exp); else passed++;
      end
      if (ov64 && r64) begin
        got = {co64, of64, s64};
        exp = (q64.size() > 0) ? q64.pop_front() : '1;
        checks++; if (got !== exp) $display("FAIL sweep64_c%0d: got %h want %h", cyc, got, exp); else passed++;
      end
    end
    v_s = 1'b0;
    checks++; if (q16.size() != 0) $display("FAIL sweep16_leftover: got %0d want 0", q16.size()); else passed++;
    checks++; if (q8.size() != 0) $display("FAIL sweep8_leftover: got %0d want 0", q8.size()); else passed++;
    checks++; if (q64.size() != 0) $display("FAIL sweep64_leftover: got %0d want 0", q64.size()); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0; in_valid = 1'b0; ina = '0; inb = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0; r16 = 1'b1; r8 = 1'b1; r64 = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
